button_debouncer: RTL and testbench
===================================

# button_debouncer

Input-conditioning stage feeding the user-project counter. Takes a raw, asynchronous, bouncing pad signal (the counter's step button), synchronises it, debounces it with a fixed stability window, and emits a clean level plus single-cycle press/release pulses. Optional auto-repeat emits periodic press pulses while the button is held. `press_pulse` drives the counter's increment enable.

## Interface

Parameters:
- `STABLE_CYCLES`, default 16: consecutive synchronised samples at the new level required to accept a transition; legal range 2..65535.
- `REPEAT_CYCLES`, default 0: auto-repeat period in cycles while held; 0 disables repeat; otherwise legal range 2..65535.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; asserts immediately, releases synchronously to `clk` at the board level.
- `btn_raw`  in  1  raw pad input, asynchronous to `clk`, active-high, may bounce.
- `btn_level`  out  1  debounced level.
- `press_pulse`  out  1  one-cycle pulse on accepted press and on each auto-repeat.
- `release_pulse`  out  1  one-cycle pulse on accepted release.

## Operation

- Synchroniser: two flops, `sync1 <= btn_raw`, `sync_q <= sync1`; both reset to 0. FSM only sees `sync_q`.
- Stability counter `cnt`, width `$clog2(STABLE_CYCLES)`; repeat counter `rpt`, width `$clog2(REPEAT_CYCLES)` (min 1).
- FSM states and transitions, evaluated each rising edge:
  - IDLE: `sync_q`=1 → PRESS_WAIT, `cnt`=1. Else stay.
  - PRESS_WAIT: `sync_q`=0 → IDLE, `cnt`=0. `sync_q`=1 and `cnt`==STABLE_CYCLES-1 → PRESSED, `btn_level`<=1, `press_pulse`<=1, `rpt`=0. Else `cnt`++.
  - PRESSED: `sync_q`=0 → RELEASE_WAIT, `cnt`=1. Else if REPEAT_CYCLES≠0: `rpt`==REPEAT_CYCLES-1 → `press_pulse`<=1, `rpt`=0; else `rpt`++.
  - RELEASE_WAIT: `sync_q`=1 → PRESSED, `cnt`=0, `rpt`=0 (repeat period restarts; no pulse). `sync_q`=0 and `cnt`==STABLE_CYCLES-1 → IDLE, `btn_level`<=0, `release_pulse`<=1. Else `cnt`++.
- Pulses are registered and default to 0 every cycle; never wider than one cycle.
- No auto-repeat pulses in RELEASE_WAIT.
- Counters never wrap: `cnt` is cleared on every state change and compared before increment; `rpt` is cleared at REPEAT_CYCLES-1.

## Timing

- Reset values: `btn_level`=0, `press_pulse`=0, `release_pulse`=0, state IDLE, `sync1`=`sync_q`=`cnt`=`rpt`=0.
- Press latency: with edge 0 being the first rising edge that samples `btn_raw`=1 (held stable), `press_pulse` and `btn_level` go high after edge STABLE_CYCLES+1. The pulse drops after edge STABLE_CYCLES+2.
- Release latency: identical, STABLE_CYCLES+1 edges from the first sampled 0.
- Repeat: the nth repeat pulse is registered n·REPEAT_CYCLES edges after the edge that registered the initial press pulse, while the state stays PRESSED.
- Any bounce (one sample at the opposite level) inside a WAIT state aborts that wait. The full window restarts on the next qualifying sample.
- Reset mid-operation: all state clears immediately; no release pulse is issued. If the button is still held after reset release, it is re-detected as a fresh press with normal latency.

## Structure

- Package `button_debouncer_pkg`: state typedef (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, 2-bit encoding) and a shared `SYNC_STAGES = 2` constant.
- Sub-module `sync_2ff` (clk, reset_n, d, q), reusable for other pad inputs.
- Parameter legality is checked with elaboration-time assertions.

## Test plan

- Reset/idle: assert `reset_n`=0 with `btn_raw`=1 → all outputs 0. Release reset and hold `btn_raw`=1 with STABLE_CYCLES=16 → single `press_pulse` after edge 17; `btn_level`=1 thereafter.
- Bounce rejection: toggle `btn_raw` 1/0 every 5 cycles for 100 cycles, then hold 1 → no pulses during the bounce; exactly one `press_pulse` 17 edges after the final stable rise.
- Release: from PRESSED, drive `btn_raw`=0 with a 1-cycle glitch to 1 at cycle 8 → `release_pulse` exactly once, 17 edges after the post-glitch 0. No extra `press_pulse`.
- Auto-repeat: REPEAT_CYCLES=10, hold 60 cycles past the press → initial press pulse plus pulses at +10, +20, ..., +60 edges. Release → repeats stop and one `release_pulse` is issued.
- Reset mid-press: assert `reset_n` during PRESSED → outputs 0 immediately and no `release_pulse`. Then release reset with the button held → re-press after 17 edges.
- Minimum window: STABLE_CYCLES=2 → press accepted after edge 3. A single-sample glitch is never accepted.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared types and constants for the button debouncer
//
// Contents:
//   SYNC_STAGES    number of flops in the pad-input synchroniser
//   state_t        debounce FSM state encoding (2 bits)
//   counter_width  width helper for the stability and repeat counters

package button_debouncer_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // $clog2 of the period, never less than one bit (a disabled repeat
    // period of 0 still gets a 1-bit counter).
    function automatic int counter_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous pad inputs
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset, clears all stages to 0
//   d        in   asynchronous input
//   q        out  input synchronised to clk

module sync_2ff
    import button_debouncer_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronise, debounce and edge-detect a push button
//
// Parameters:
//   STABLE_CYCLES  samples at the new level needed to accept a transition (2..65535)
//   REPEAT_CYCLES  auto-repeat period while held; 0 disables (else 2..65535)
//
// Ports:
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   btn_raw        in   raw, bouncing, asynchronous pad input (active high)
//   btn_level      out  debounced level
//   press_pulse    out  one-cycle pulse on accepted press and each auto-repeat
//   release_pulse  out  one-cycle pulse on accepted release

module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_CYCLES = 0
)
(
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = counter_width(STABLE_CYCLES);
    localparam int RW = counter_width(REPEAT_CYCLES);
    localparam bit REPEAT_EN = (REPEAT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RPT_LAST = REPEAT_EN ? RW'(REPEAT_CYCLES - 1) : '0;

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535) begin : g_bad_stable
        $error("button_debouncer: STABLE_CYCLES must be in 2..65535");
    end

    if (REPEAT_CYCLES != 0 && (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535)) begin : g_bad_repeat
        $error("button_debouncer: REPEAT_CYCLES must be 0 or in 2..65535");
    end

    logic            sync_q;
    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [RW-1:0]   rpt_q;
    logic [RW-1:0]   rpt_d;
    logic            level_d;
    logic            press_d;
    logic            release_d;

    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn_raw),
        .q       (sync_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rpt_q         <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rpt_q         <= rpt_d;
            btn_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

    // The window counter is compared before it is incremented and cleared
    // on every state change, so it never needs to hold STABLE_CYCLES itself.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rpt_d     = rpt_q;
        level_d   = btn_level;
        press_d   = 1'b0;
        release_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sync_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end

            PRESS_WAIT: begin
                if (!sync_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    rpt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            PRESSED: begin
                if (!sync_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CW'(1);
                end else if (REPEAT_EN) begin
                    if (rpt_q == RPT_LAST) begin
                        press_d = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_q + RW'(1);
                    end
                end
            end

            RELEASE_WAIT: begin
                // A bounce back to 1 returns to PRESSED silently and restarts
                // the repeat period from zero.
                if (sync_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    rpt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                rpt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer

module tb_button_debouncer;

    logic       clk;
    logic       reset_n;
    logic       btn_raw;
    logic [2:0] lvl;
    logic [2:0] pp;
    logic [2:0] rp;

    int n_tests;
    int n_fail;

    // Configurations: 0 = S16/no repeat, 1 = S16/R10, 2 = S2/no repeat
    int s_tab [3] = '{16, 16, 2};
    int r_tab [3] = '{0, 10, 0};

    button_debouncer #(.STABLE_CYCLES(16), .REPEAT_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
        .btn_level(lvl[0]), .press_pulse(pp[0]), .release_pulse(rp[0]));

    button_debouncer #(.STABLE_CYCLES(16), .REPEAT_CYCLES(10)) dut1 (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
        .btn_level(lvl[1]), .press_pulse(pp[1]), .release_pulse(rp[1]));

    button_debouncer #(.STABLE_CYCLES(2), .REPEAT_CYCLES(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
        .btn_level(lvl[2]), .press_pulse(pp[2]), .release_pulse(rp[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: accepted level flips once S consecutive synchronised
    // samples disagree with it; while held, a repeat pulse every R agreeing
    // samples, with the period restarting after any aborted release.
    bit m_lvl [3];
    int m_run [3];
    int m_rc  [3];
    bit m_p   [3];
    bit m_r   [3];
    bit sync_pipe [$];
    int cnt_p [3];
    int cnt_r [3];

    task automatic model_step(input bit r, input bit b);
        bit s;
        if (!r) begin
            sync_pipe = '{1'b0, 1'b0};
            for (int i = 0; i < 3; i++) begin
                m_lvl[i] = 0; m_run[i] = 0; m_rc[i] = 0; m_p[i] = 0; m_r[i] = 0;
            end
        end else begin
            s = sync_pipe.pop_front();
            sync_pipe.push_back(b);
            for (int i = 0; i < 3; i++) begin
                m_p[i] = 0;
                m_r[i] = 0;
                if (s != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == s_tab[i]) begin
                        m_lvl[i] = s;
                        m_run[i] = 0;
                        m_rc[i]  = 0;
                        if (s) m_p[i] = 1; else m_r[i] = 1;
                    end
                end else begin
                    if (m_lvl[i] && r_tab[i] != 0) begin
                        if (m_run[i] > 0) begin
                            m_rc[i] = 0;
                        end else begin
                            m_rc[i]++;
                            if (m_rc[i] == r_tab[i]) begin
                                m_p[i]  = 1;
                                m_rc[i] = 0;
                            end
                        end
                    end
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock: drive, let the edge happen, sample 1 ns later, compare all
    // three instances with the model.
    task automatic cyc(input bit r, input bit b);
        reset_n = r;
        btn_raw = b;
        @(posedge clk);
        #1;
        model_step(r, b);
        for (int i = 0; i < 3; i++) begin
            cnt_p[i] += int'(pp[i]);
            cnt_r[i] += int'(rp[i]);
            chk($sformatf("model_level%0d", i),   lvl[i], m_lvl[i]);
            chk($sformatf("model_press%0d", i),   pp[i],  m_p[i]);
            chk($sformatf("model_release%0d", i), rp[i],  m_r[i]);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            cnt_p[i] = 0;
            cnt_r[i] = 0;
        end
    endtask

    typedef struct {
        bit rst;
        bit btn;
        int n;
        int press;
        int rel;
        bit level;
    } vec_t;

    vec_t tbl [$];

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        btn_raw = 1'b1;
        sync_pipe = '{1'b0, 1'b0};
        clear_counts();

        // Table for instance 0 (S=16, no repeat): pulse counts per segment
        tbl.push_back('{0, 1, 3,  0, 0, 0});   // reset held with button down
        tbl.push_back('{1, 1, 20, 1, 0, 1});   // clean press
        tbl.push_back('{1, 0, 7,  0, 0, 1});   // release begins
        tbl.push_back('{1, 1, 1,  0, 0, 1});   // one-cycle glitch back to 1
        tbl.push_back('{1, 0, 20, 0, 1, 0});   // release accepted after glitch
        for (int k = 0; k < 20; k++)
            tbl.push_back('{1, bit'(~k[0]), 5, 0, 0, 0});  // 100 cycles of bounce
        tbl.push_back('{1, 1, 20, 1, 0, 1});   // stable press after bounce
        tbl.push_back('{1, 0, 20, 0, 1, 0});   // stable release

        for (int t = 0; t < tbl.size(); t++) begin
            clear_counts();
            for (int c = 0; c < tbl[t].n; c++) cyc(tbl[t].rst, tbl[t].btn);
            chk_int($sformatf("tbl%0d_press", t),   cnt_p[0], tbl[t].press);
            chk_int($sformatf("tbl%0d_release", t), cnt_r[0], tbl[t].rel);
            chk($sformatf("tbl%0d_level", t), lvl[0], tbl[t].level);
        end

        // Reset mid-press: outputs drop without a clock, no release pulse,
        // then re-press with normal latency.
        for (int c = 0; c < 20; c++) cyc(1, 1);
        chk("midreset_pre_level", lvl[0], 1'b1);
        reset_n = 1'b0;
        #1;
        chk("midreset_async_level0", lvl[0], 1'b0);
        chk("midreset_async_level1", lvl[1], 1'b0);
        chk("midreset_async_level2", lvl[2], 1'b0);
        clear_counts();
        for (int c = 0; c < 3; c++) cyc(0, 1);
        chk_int("midreset_no_release", cnt_r[0], 0);
        for (int k = 0; k < 20; k++) begin
            cyc(1, 1);
            chk($sformatf("repress_latency_k%0d", k), pp[0], (k == 17) ? 1'b1 : 1'b0);
        end
        chk("repress_level", lvl[0], 1'b1);

        // Auto-repeat on instance 1: press at edge 17, repeats every 10
        for (int c = 0; c < 2; c++) cyc(0, 0);
        clear_counts();
        for (int k = 0; k < 78; k++) begin
            cyc(1, 1);
            chk($sformatf("repeat_k%0d", k), pp[1],
                (k >= 17 && (k - 17) % 10 == 0) ? 1'b1 : 1'b0);
        end
        chk_int("repeat_total", cnt_p[1], 7);
        clear_counts();
        for (int c = 0; c < 30; c++) cyc(1, 0);
        chk_int("repeat_stop_press", cnt_p[1], 0);
        chk_int("repeat_stop_release", cnt_r[1], 1);

        // Minimum window on instance 2 (S=2)
        for (int c = 0; c < 2; c++) cyc(0, 0);
        for (int k = 0; k < 6; k++) begin
            cyc(1, 1);
            chk($sformatf("min_window_k%0d", k), pp[2], (k == 3) ? 1'b1 : 1'b0);
        end
        for (int c = 0; c < 10; c++) cyc(1, 0);
        clear_counts();
        cyc(1, 1);
        for (int c = 0; c < 10; c++) cyc(1, 0);
        chk_int("min_glitch_press", cnt_p[2], 0);
        chk("min_glitch_level", lvl[2], 1'b0);

        // Random hold lengths with occasional resets, model-checked per cycle
        for (int seg = 0; seg < 200; seg++) begin
            int len;
            bit b;
            len = int'($urandom_range(1, 25));
            b   = bit'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) begin
                for (int c = 0; c < 2; c++) cyc(0, b);
            end
            for (int c = 0; c < len; c++) cyc(1, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
